// File: rtl/register.sv
// Parameterised signed data register: a STAGES-deep chain of WIDTH-bit flops with a matching valid chain.
// Latency: STAGES rising edges from input_port to output_latch; one word per cycle.
// Backpressure: none; every non-reset edge loads, so holding a value means holding the input.
module register #(
    parameter int                      WIDTH       = 64,
    parameter int                      STAGES      = 1,
    parameter logic signed [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [WIDTH-1:0]  input_port,
    output logic signed [WIDTH-1:0]  output_latch,
    output logic                     output_valid
);

    logic signed [WIDTH-1:0] stage_q [STAGES];
    logic signed [WIDTH-1:0] stage_d [STAGES];
    logic [STAGES-1:0]       valid_q;
    logic [STAGES-1:0]       valid_d;

    always_comb begin
        stage_d[0] = input_port;
        valid_d    = '0;
        valid_d[0] = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
    end

    // Reset wins over new data on the same edge and discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= RESET_VALUE;
            end
            valid_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            valid_q <= valid_d;
        end
    end

    assign output_latch = stage_q[STAGES-1];
    assign output_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_register.sv
// Directed bench for register: default build, a 3-stage build and an 8-bit build with a non-zero reset value.
module tb_register;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c;
    logic [63:0] in_a, in_b;
    logic [7:0]  in_c;
    logic [63:0] out_a, out_b;
    logic [7:0]  out_c;
    logic        vld_a, vld_b, vld_c;

    int n_cmp = 0;
    int n_err = 0;

    register u_dflt (
        .clk(clk), .rst(rst_a), .input_port(in_a),
        .output_latch(out_a), .output_valid(vld_a)
    );

    register #(.STAGES(3)) u_pipe (
        .clk(clk), .rst(rst_b), .input_port(in_b),
        .output_latch(out_b), .output_valid(vld_b)
    );

    register #(.WIDTH(8), .RESET_VALUE(8'h5A)) u_narrow (
        .clk(clk), .rst(rst_c), .input_port(in_c),
        .output_latch(out_c), .output_valid(vld_c)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        in_a  = 64'h1234; in_b = 64'h1234; in_c = 8'hFF;

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_a", out_a, 64'h0);
            chk("rst_vld_a", {63'h0, vld_a}, 64'h0);
            chk("rst_out_b", out_b, 64'h0);
            chk("rst_out_c", {56'h0, out_c}, 64'h5A);
            chk("rst_vld_c", {63'h0, vld_c}, 64'h0);
        end

        // Default build: single load, then output must stay put until the next edge.
        rst_a = 1'b0; in_a = 64'hDB6DB6DB6DB6DB6D;
        rst_c = 1'b0; in_c = 8'h80;
        tick();
        chk("load_out_a", out_a, 64'hDB6DB6DB6DB6DB6D);
        chk("load_vld_a", {63'h0, vld_a}, 64'h1);
        chk("narrow_out_c", {56'h0, out_c}, 64'h80);
        chk("narrow_vld_c", {63'h0, vld_c}, 64'h1);
        #1 in_a = 64'h0F0F0F0F0F0F0F0F;
        #6;
        chk("no_comb_path_a", out_a, 64'hDB6DB6DB6DB6DB6D);

        in_a = 64'h1;
        tick();
        chk("stream_one", out_a, 64'h1);
        in_a = 64'h8000000000000000;
        tick();
        chk("stream_minneg", out_a, 64'h8000000000000000);
        chk("minneg_signed", {63'h0, $signed(out_a) < 0}, 64'h1);
        in_a = 64'hFFFFFFFFFFFFFFFF;
        tick();
        chk("stream_all1", out_a, 64'hFFFFFFFFFFFFFFFF);
        chk("all1_is_m1", {63'h0, $signed(out_a) == -64'sd1}, 64'h1);

        in_a = 64'hA5A5A5A5C3C3C3C3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_a", out_a, 64'hA5A5A5A5C3C3C3C3);
            chk("hold_vld_a", {63'h0, vld_a}, 64'h1);
        end

        // Three-stage build: fill, mid-stream reset, refill.
        rst_b = 1'b0; in_b = 64'h11;
        tick();
        chk("pipe_fill1_vld", {63'h0, vld_b}, 64'h0);
        in_b = 64'h22;
        tick();
        chk("pipe_fill2_vld", {63'h0, vld_b}, 64'h0);
        in_b = 64'h33;
        tick();
        chk("pipe_fill3_out", out_b, 64'h11);
        chk("pipe_fill3_vld", {63'h0, vld_b}, 64'h1);
        rst_b = 1'b1; in_b = 64'h44;
        tick();
        chk("pipe_rst_out", out_b, 64'h0);
        chk("pipe_rst_vld", {63'h0, vld_b}, 64'h0);
        rst_b = 1'b0; in_b = 64'h55;
        tick();
        chk("pipe_re1_out", out_b, 64'h0);
        chk("pipe_re1_vld", {63'h0, vld_b}, 64'h0);
        in_b = 64'h66;
        tick();
        chk("pipe_re2_out", out_b, 64'h0);
        chk("pipe_re2_vld", {63'h0, vld_b}, 64'h0);
        in_b = 64'h77;
        tick();
        chk("pipe_re3_out", out_b, 64'h55);
        chk("pipe_re3_vld", {63'h0, vld_b}, 64'h1);
        tick();
        chk("pipe_re4_out", out_b, 64'h66);

        // Narrow build: reset again mid-run restores the non-zero reset value.
        rst_c = 1'b1; in_c = 8'h3C;
        tick();
        chk("narrow_rst_out", {56'h0, out_c}, 64'h5A);
        chk("narrow_rst_vld", {63'h0, vld_c}, 64'h0);
        rst_c = 1'b0;
        tick();
        chk("narrow_after_out", {56'h0, out_c}, 64'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
